// File: rtl/cc_pkg.sv
// Shared definitions for the cc request arbiter slice: FSM encoding,
// decode-order channel indices and default sizing.
package cc_pkg;

  localparam int N_REQ_DEF    = 8;
  localparam int HOLD_MAX_DEF = 15;

  // Channel index of each decode enable strobe in the request vector
  localparam int CH_PI0 = 0;
  localparam int CH_PJ0 = 1;
  localparam int CH_PK0 = 2;
  localparam int CH_PL0 = 3;
  localparam int CH_PM0 = 4;
  localparam int CH_PN0 = 5;
  localparam int CH_PO0 = 6;
  localparam int CH_PP0 = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } cc_state_e;

endpackage

// File: rtl/cc_rr_pick.sv
// Round-robin picker: first set bit of pending at or after rr_ptr,
// wrapping modulo N_REQ. Purely combinational.
module cc_rr_pick #(
  parameter int N_REQ = 8,
  parameter int IDX_W = 3
) (
  input  logic [N_REQ-1:0] pending,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W:0] pos;

  // Scan offsets 0..N_REQ-1 from rr_ptr; the first hit wins
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pos = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (pos >= (IDX_W+1)'(N_REQ)) pos = pos - (IDX_W+1)'(N_REQ);
      if (!found && pending[pos[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/cc_req_arbiter.sv
// Captures decode enable strobes into a pending register and issues one
// registered round-robin grant at a time, closed by ack or by timeout.
module cc_req_arbiter
  import cc_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int IDX_W    = 3,
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [N_REQ-1:0] req_vec,
  output logic             req_ready,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N_REQ-1:0] gnt_onehot,
  input  logic             gnt_ack,
  output logic [N_REQ-1:0] pending,
  output logic             timeout_err,
  input  logic             err_clr,
  output logic             busy
);

  cc_state_e        state;
  logic [IDX_W-1:0] rr_ptr;
  logic [7:0]       hold_cnt;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             in_grant;
  logic             hold_hit;
  logic             release_gnt;
  logic             timeout;
  logic             accepted;
  logic [N_REQ-1:0] clr_mask;
  logic [N_REQ-1:0] pend_next;
  logic [IDX_W-1:0] nxt_ptr;

  cc_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .pending (pending),
    .rr_ptr  (rr_ptr),
    .found   (pick_found),
    .idx     (pick_idx)
  );

  assign req_ready = (pending != {N_REQ{1'b1}});
  assign busy      = (state != ST_IDLE) || (pending != '0);
  assign accepted  = req_valid & req_ready;

  // Grant close-out: ack ends it, otherwise the hold limit forces it
  always_comb begin
    in_grant    = (state == ST_GRANT);
    hold_hit    = (hold_cnt == 8'(HOLD_MAX-1));
    release_gnt = in_grant & (gnt_ack | hold_hit);
    timeout     = in_grant & ~gnt_ack & hold_hit;
    clr_mask    = release_gnt ? ({{(N_REQ-1){1'b0}}, 1'b1} << gnt_idx) : '0;
    nxt_ptr     = (gnt_idx == IDX_W'(N_REQ-1)) ? '0 : gnt_idx + IDX_W'(1);
    // set term last so a fresh request for the closing channel survives
    pend_next   = (pending & ~clr_mask) | (accepted ? req_vec : '0);
  end

  // Pending register, grant FSM and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pending     <= '0;
      rr_ptr      <= '0;
      hold_cnt    <= '0;
      gnt_valid   <= 1'b0;
      gnt_idx     <= '0;
      gnt_onehot  <= '0;
      timeout_err <= 1'b0;
    end else begin
      pending <= pend_next;
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            gnt_idx    <= pick_idx;
            gnt_onehot <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
            gnt_valid  <= 1'b1;
            hold_cnt   <= '0;
            state      <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (release_gnt) begin
            gnt_valid  <= 1'b0;
            gnt_onehot <= '0;
            rr_ptr     <= nxt_ptr;
            state      <= ST_GAP;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        ST_GAP:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      if (timeout)      timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cc_req_arbiter.sv
// Bench for cc_req_arbiter: reset checks, a cycle table for round-robin
// order, directed corner sequences, then random traffic against a model.
module tb_cc_req_arbiter;

  localparam int N        = 8;
  localparam int HOLD_MAX = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [7:0] req_vec = '0;
  logic       req_ready;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic [7:0] gnt_onehot;
  logic       gnt_ack = 1'b0;
  logic [7:0] pending;
  logic       timeout_err;
  logic       err_clr = 1'b0;
  logic       busy;

  int errors = 0;
  int checks = 0;

  cc_req_arbiter #(.N_REQ(N), .IDX_W(3), .HOLD_MAX(HOLD_MAX)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_vec     (req_vec),
    .req_ready   (req_ready),
    .gnt_valid   (gnt_valid),
    .gnt_idx     (gnt_idx),
    .gnt_onehot  (gnt_onehot),
    .gnt_ack     (gnt_ack),
    .pending     (pending),
    .timeout_err (timeout_err),
    .err_clr     (err_clr),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Bounded wait for a grant, then compare index and ack it
  task automatic grant_and_ack(input int exp_idx, input string nm);
    int n;
    n = 0;
    while (!gnt_valid && n < 20) begin
      tick();
      n++;
    end
    chk({nm, "_seen"}, 32'(gnt_valid), 32'd1);
    chk({nm, "_idx"}, 32'(gnt_idx), 32'(exp_idx));
    gnt_ack = 1'b1;
    tick();
    gnt_ack = 1'b0;
  endtask

  typedef struct {
    logic       rv;
    logic [7:0] vec;
    logic       ack;
    logic       gv;
    logic [2:0] idx;
    logic [7:0] pend;
    logic       bsy;
  } vec_t;

  vec_t tv[10];

  // Reference model state
  bit [7:0] m_pend;
  int       m_gnt;
  bit       m_gap;
  int       m_ptr;
  int       m_hold;
  bit       m_terr;

  function automatic void model_reset();
    m_pend = '0; m_gnt = -1; m_gap = 1'b0; m_ptr = 0; m_hold = 0; m_terr = 1'b0;
  endfunction

  function automatic void model_step(input bit r, input bit rv, input bit [7:0] vec,
                                     input bit ack, input bit eclr);
    bit       acc;
    bit       to;
    bit       found;
    bit [7:0] clr;
    if (r) begin
      model_reset();
      return;
    end
    acc = rv && (m_pend != 8'hFF);
    clr = '0;
    to  = 1'b0;
    if (m_gnt >= 0) begin
      if (ack || m_hold == HOLD_MAX-1) begin
        clr    = 8'(1 << m_gnt);
        to     = !ack;
        m_ptr  = (m_gnt + 1) % N;
        m_gnt  = -1;
        m_gap  = 1'b1;
      end else begin
        m_hold++;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (m_pend != 0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (!found && m_pend[c]) begin
          found  = 1'b1;
          m_gnt  = c;
          m_hold = 0;
        end
      end
    end
    if (to) m_terr = 1'b1;
    else if (eclr) m_terr = 1'b0;
    m_pend = (m_pend & ~clr) | (acc ? vec : 8'h00);
  endfunction

  initial begin
    int n;
    bit exp_gv;

    // Reset with traffic offered
    rst = 1'b1; req_valid = 1'b1; req_vec = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_pending", 32'(pending), 32'h0);
      chk("rst_gnt_valid", 32'(gnt_valid), 32'h0);
      chk("rst_timeout_err", 32'(timeout_err), 32'h0);
      chk("rst_onehot", 32'(gnt_onehot), 32'h0);
    end
    rst = 1'b0; req_valid = 1'b0; req_vec = '0;
    tick();
    chk("idle_req_ready", 32'(req_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_pending", 32'(pending), 32'd0);

    // Round-robin order 0, 2, 7 for request 8'b1000_0101, cycle by cycle
    tv[0] = '{1'b1, 8'h85, 1'b0, 1'b0, 3'd0, 8'h85, 1'b1};
    tv[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 8'h85, 1'b1};
    tv[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h84, 1'b1};
    tv[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h84, 1'b1};
    tv[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd2, 8'h84, 1'b1};
    tv[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h80, 1'b1};
    tv[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h80, 1'b1};
    tv[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd7, 8'h80, 1'b1};
    tv[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1};
    tv[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0};
    for (int i = 0; i < 10; i++) begin
      req_valid = tv[i].rv; req_vec = tv[i].vec; gnt_ack = tv[i].ack;
      tick();
      chk($sformatf("rr%0d_gnt_valid", i), 32'(gnt_valid), 32'(tv[i].gv));
      if (tv[i].gv) chk($sformatf("rr%0d_gnt_idx", i), 32'(gnt_idx), 32'(tv[i].idx));
      chk($sformatf("rr%0d_onehot", i), 32'(gnt_onehot),
          tv[i].gv ? (32'd1 << tv[i].idx) : 32'd0);
      chk($sformatf("rr%0d_pending", i), 32'(pending), 32'(tv[i].pend));
      chk($sformatf("rr%0d_busy", i), 32'(busy), 32'(tv[i].bsy));
    end
    req_valid = 1'b0; req_vec = '0; gnt_ack = 1'b0;

    // Wrap: grant 5 first so the pointer sits at 6, then 8'b0100_0011
    req_valid = 1'b1; req_vec = 8'h20; tick(); req_valid = 1'b0; req_vec = '0;
    grant_and_ack(5, "wrap_pre");
    req_valid = 1'b1; req_vec = 8'h43; tick(); req_valid = 1'b0; req_vec = '0;
    grant_and_ack(6, "wrap_a");
    grant_and_ack(0, "wrap_b");
    grant_and_ack(1, "wrap_c");
    tick(); tick();
    chk("wrap_drained", 32'(busy), 32'd0);

    // Timeout on channel 3 (pointer is 2 here)
    req_valid = 1'b1; req_vec = 8'h08; tick(); req_valid = 1'b0; req_vec = '0;
    n = 0;
    while (!gnt_valid && n < 20) begin tick(); n++; end
    chk("to_idx", 32'(gnt_idx), 32'd3);
    n = 0;
    while (gnt_valid && n < 40) begin tick(); n++; end
    chk("to_hold_cycles", 32'(n), 32'(HOLD_MAX));
    chk("to_err_set", 32'(timeout_err), 32'd1);
    chk("to_pending", 32'(pending), 32'd0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("to_err_clr", 32'(timeout_err), 32'd0);
    tick();

    // Set-over-clear: re-request channel 4 in the same cycle it is acked
    req_valid = 1'b1; req_vec = 8'h10; tick(); req_valid = 1'b0; req_vec = '0;
    n = 0;
    while (!gnt_valid && n < 20) begin tick(); n++; end
    chk("coll_idx", 32'(gnt_idx), 32'd4);
    gnt_ack = 1'b1; req_valid = 1'b1; req_vec = 8'h10;
    tick();
    gnt_ack = 1'b0; req_valid = 1'b0; req_vec = '0;
    chk("coll_pending", 32'(pending), 32'h10);
    chk("coll_gap", 32'(gnt_valid), 32'd0);
    tick();
    chk("coll_idle", 32'(gnt_valid), 32'd0);
    tick();
    chk("coll_regrant", 32'(gnt_valid), 32'd1);
    chk("coll_regrant_idx", 32'(gnt_idx), 32'd4);
    gnt_ack = 1'b1; tick(); gnt_ack = 1'b0;
    tick(); tick();

    // Saturation: pending all ones blocks new requests (pointer is 5)
    req_valid = 1'b1; req_vec = 8'hFF; tick();
    chk("sat_ready_low", 32'(req_ready), 32'd0);
    req_vec = 8'h01; tick();
    chk("sat_gnt_idx", 32'(gnt_idx), 32'd5);
    chk("sat_pending_full", 32'(pending), 32'hFF);
    req_vec = 8'h20; gnt_ack = 1'b1; tick();
    gnt_ack = 1'b0; req_valid = 1'b0; req_vec = '0;
    chk("sat_not_accepted", 32'(pending), 32'hDF);
    chk("sat_ready_back", 32'(req_ready), 32'd1);

    // Random traffic against the reference model
    rst = 1'b1; model_step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0); tick(); rst = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst       = ($urandom_range(0, 299) == 0);
      req_valid = ($urandom_range(0, 3) == 0);
      req_vec   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom());
      gnt_ack   = ($urandom_range(0, 3) == 0);
      err_clr   = ($urandom_range(0, 9) == 0);
      model_step(rst, req_valid, req_vec, gnt_ack, err_clr);
      tick();
      exp_gv = (m_gnt >= 0);
      chk("rnd_gnt_valid", 32'(gnt_valid), 32'(exp_gv));
      if (exp_gv) chk("rnd_gnt_idx", 32'(gnt_idx), 32'(m_gnt));
      chk("rnd_onehot", 32'(gnt_onehot), exp_gv ? (32'd1 << m_gnt) : 32'd0);
      chk("rnd_pending", 32'(pending), 32'(m_pend));
      chk("rnd_req_ready", 32'(req_ready), 32'(m_pend != 8'hFF));
      chk("rnd_busy", 32'(busy), 32'(exp_gv || m_gap || m_pend != 0));
      chk("rnd_timeout_err", 32'(timeout_err), 32'(m_terr));
    end
    rst = 1'b0; req_valid = 1'b0; gnt_ack = 1'b0; err_clr = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
